// File: rtl/bus_grant_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// bus_grant_scheduler_pkg
// Shared definitions for the 12-master bus: master id type, "no master"
// encoding, priority class encodings, scheduler FSM state encoding and the
// mid -> one-hot grant decode (also used by the split controller).
// -----------------------------------------------------------------------------
package bus_grant_scheduler_pkg;

   localparam int NUM_MASTERS = 12;

   typedef logic [3:0] mid_t;

   localparam mid_t MID_NONE = 4'hF;

   // Priority classes; a lower code is a higher priority.
   localparam logic [1:0] CLS_P1 = 2'd0;   // mids 0-3
   localparam logic [1:0] CLS_P2 = 2'd1;   // mids 4-7
   localparam logic [1:0] CLS_P3 = 2'd2;   // mids 8-11

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARB       = 3'd1,
      WAIT_FREE = 3'd2,
      GRANT     = 3'd3,
      HOLD      = 3'd4
   } state_t;

   // One-hot grant vector for a master id; out-of-range ids (incl. MID_NONE)
   // decode to no grant.
   function automatic logic [NUM_MASTERS-1:0] mid_to_grant(input mid_t mid);
      logic [NUM_MASTERS-1:0] grant;
      grant = '0;
      if (mid < 4'(NUM_MASTERS)) begin
         grant = NUM_MASTERS'(1) << mid;
      end
      return grant;
   endfunction

endpackage

// File: rtl/bus_grant_scheduler_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational 4-way round-robin picker. Scans req starting at ptr+1 and
// wrapping mod 4; ptr itself is the last position examined.
//   req    in  4  request vector (local indices 0-3)
//   ptr    in  2  index of the previous winner
//   valid  out 1  any request present
//   winner out 2  local index of the chosen request (ptr when none)
// -----------------------------------------------------------------------------
module rr_pick4
   import bus_grant_scheduler_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       valid,
   output logic [1:0] winner
);

   logic [1:0] idx;

   // Walk offsets from farthest (4 == ptr) to nearest (1 == ptr+1); the last
   // hit written is the closest one after ptr.
   always_comb begin
      valid  = 1'b0;
      winner = ptr;
      idx    = '0;
      for (int i = 4; i >= 1; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/bus_grant_scheduler.sv
// -----------------------------------------------------------------------------
// bus_grant_scheduler
// Fair grant scheduler for the shared 12-master bus. Three fixed-priority
// classes of four masters, round-robin inside a class, split-blocked masters
// masked out. Enforces a grant pickup timeout and raises preempt when a master
// has held the bus for MAX_TENURE cycles while an equal/higher class waits.
//   clk          in  1   system clock
//   rstn         in  1   asynchronous active-low reset
//   m_reqs       in  12  per-master request (level)
//   m_blocked    in  12  master waiting on a split slave; request ignored
//   bus_util     in  1   1 = bus free/released, 0 = bus held by a master
//   m_grants     out 12  registered one-hot grant
//   mid_current  out 4   granted master id, MID_NONE when none
//   preempt      out 1   level request for the owner to finish and release
//   timeout_err  out 1   one-cycle pulse when a grant is not picked up
//   state        out 3   FSM state (debug)
// -----------------------------------------------------------------------------
module bus_grant_scheduler
   import bus_grant_scheduler_pkg::*;
#(
   parameter int MAX_TENURE  = 64,
   parameter int ACK_TIMEOUT = 8,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [11:0] m_reqs,
   input  logic [11:0] m_blocked,
   input  logic        bus_util,
   output logic [11:0] m_grants,
   output logic [3:0]  mid_current,
   output logic        preempt,
   output logic        timeout_err,
   output logic [2:0]  state
);

   localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TENURE_MAX = CNT_W'(MAX_TENURE);

   state_t            state_reg,   state_next;
   mid_t              mid_sel_reg, mid_sel_next;
   logic [1:0]        cls_sel_reg, cls_sel_next;
   logic [CNT_W-1:0]  cnt_reg,     cnt_next;
   logic [2:0][1:0]   rr_ptr_reg,  rr_ptr_next;
   logic [11:0]       grants_reg,  grants_next;
   mid_t              mid_cur_reg, mid_cur_next;

   logic [11:0]       elig;
   logic [2:0]        cls_valid;
   logic [2:0][1:0]   cls_win;
   logic [11:0]       contend;

   assign elig = m_reqs & ~m_blocked;

   // One round-robin picker per priority class.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_pick
         rr_pick4 u_pick (
            .req    (elig[gi*4 +: 4]),
            .ptr    (rr_ptr_reg[gi]),
            .valid  (cls_valid[gi]),
            .winner (cls_win[gi])
         );
      end
   endgenerate

   // Masters that justify preempting the owner: eligible, not the owner, and
   // in the owner's class or a higher-priority one.
   generate
      for (genvar gi = 0; gi < 12; gi++) begin : g_contend
         assign contend[gi] = elig[gi]
                            && (2'(gi / 4) <= cls_sel_reg)
                            && (4'(gi) != mid_sel_reg);
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg   <= IDLE;
         mid_sel_reg <= MID_NONE;
         cls_sel_reg <= CLS_P1;
         cnt_reg     <= '0;
         rr_ptr_reg  <= '1;          // every pointer = 3, first scan starts at 0
         grants_reg  <= '0;
         mid_cur_reg <= MID_NONE;
      end else begin
         state_reg   <= state_next;
         mid_sel_reg <= mid_sel_next;
         cls_sel_reg <= cls_sel_next;
         cnt_reg     <= cnt_next;
         rr_ptr_reg  <= rr_ptr_next;
         grants_reg  <= grants_next;
         mid_cur_reg <= mid_cur_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      mid_sel_next = mid_sel_reg;
      cls_sel_next = cls_sel_reg;
      cnt_next     = cnt_reg;
      rr_ptr_next  = rr_ptr_reg;
      grants_next  = '0;
      mid_cur_next = MID_NONE;
      preempt      = 1'b0;
      timeout_err  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (|elig) state_next = ARB;
         end

         ARB: begin
            // Highest class with any eligible request wins.
            if (cls_valid[0]) begin
               cls_sel_next = CLS_P1;
               mid_sel_next = {CLS_P1, cls_win[0]};
               state_next   = WAIT_FREE;
            end else if (cls_valid[1]) begin
               cls_sel_next = CLS_P2;
               mid_sel_next = {CLS_P2, cls_win[1]};
               state_next   = WAIT_FREE;
            end else if (cls_valid[2]) begin
               cls_sel_next = CLS_P3;
               mid_sel_next = {CLS_P3, cls_win[2]};
               state_next   = WAIT_FREE;
            end else begin
               state_next   = IDLE;
            end
         end

         WAIT_FREE: begin
            // A withdrawn or newly blocked winner forfeits without moving
            // the round-robin pointer.
            if (~|(elig & mid_to_grant(mid_sel_reg))) begin
               state_next = IDLE;
            end else if (bus_util) begin
               state_next = GRANT;
               cnt_next   = '0;
            end
         end

         GRANT: begin
            if (!bus_util) begin
               state_next = HOLD;
               cnt_next   = '0;
            end else if (cnt_reg >= ACK_LAST) begin
               // Dead master: drop the grant and pass its turn on.
               timeout_err              = 1'b1;
               rr_ptr_next[cls_sel_reg] = mid_sel_reg[1:0];
               state_next               = IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         HOLD: begin
            preempt = (cnt_reg >= TENURE_MAX) && (|contend);
            if (bus_util) begin
               rr_ptr_next[cls_sel_reg] = mid_sel_reg[1:0];
               state_next               = IDLE;
            end else if (cnt_reg < TENURE_MAX) begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Grant outputs are registered and follow the next state, so the grant
      // appears with the first GRANT cycle and drops with the exit from HOLD.
      if (state_next == GRANT || state_next == HOLD) begin
         grants_next  = mid_to_grant(mid_sel_next);
         mid_cur_next = mid_sel_next;
      end
   end

   assign m_grants    = grants_reg;
   assign mid_current = mid_cur_reg;
   assign state       = state_reg;

endmodule

// File: tb/tb_bus_grant_scheduler.sv
module tb_bus_grant_scheduler;

   localparam int ACK = 8;
   localparam int TEN = 64;

   logic        clk = 1'b0;
   logic        rstn;
   logic [11:0] m_reqs;
   logic [11:0] m_blocked;
   logic        bus_util;
   logic [11:0] m_grants;
   logic [3:0]  mid_current;
   logic        preempt;
   logic        timeout_err;
   logic [2:0]  state;

   int total = 0;
   int bad   = 0;

   bus_grant_scheduler dut (
      .clk         (clk),
      .rstn        (rstn),
      .m_reqs      (m_reqs),
      .m_blocked   (m_blocked),
      .bus_util    (bus_util),
      .m_grants    (m_grants),
      .mid_current (mid_current),
      .preempt     (preempt),
      .timeout_err (timeout_err),
      .state       (state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 quiet, 1 choosing, 2 waiting for free bus, 3 offered, 4 owned
   int phase;
   int owner;
   int owner_cls;
   int age;
   int last_won [3];

   task automatic model_reset();
      phase = 0; owner = 15; owner_cls = 0; age = 0;
      for (int c = 0; c < 3; c++) last_won[c] = 3;
   endtask

   function automatic int choose(input logic [11:0] e);
      for (int c = 0; c < 3; c++)
         for (int k = 1; k <= 4; k++)
            if (e[c*4 + (last_won[c] + k) % 4]) return c*4 + (last_won[c] + k) % 4;
      return -1;
   endfunction

   function automatic bit want_preempt(input logic [11:0] e);
      if (phase != 4 || age < TEN) return 1'b0;
      for (int j = 0; j < 12; j++)
         if (j != owner && j / 4 <= owner_cls && e[j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(input logic [11:0] e, input logic u);
      int w;
      case (phase)
         0: if (e != 0) phase = 1;
         1: begin
            w = choose(e);
            if (w < 0) phase = 0;
            else begin owner = w; owner_cls = w / 4; phase = 2; end
         end
         2: begin
            if (!e[owner]) phase = 0;
            else if (u) begin phase = 3; age = 0; end
         end
         3: begin
            if (!u) begin phase = 4; age = 0; end
            else if (age == ACK - 1) begin last_won[owner_cls] = owner % 4; phase = 0; end
            else age++;
         end
         default: begin
            if (u) begin last_won[owner_cls] = owner % 4; phase = 0; end
            else if (age < TEN) age++;
         end
      endcase
   endtask

   // ---------------- stimulus helpers ----------------
   logic seen_tout, seen_pre;

   task automatic cycle(input logic [11:0] r, input logic [11:0] b, input logic u);
      logic [11:0] e;
      logic [11:0] eg;
      #1;
      m_reqs = r; m_blocked = b; bus_util = u;
      e = r & ~b;
      @(negedge clk);
      eg = (phase >= 3) ? (12'd1 << owner) : 12'd0;
      check_val("grants", m_grants, eg);
      check_val("mid", mid_current, (phase >= 3) ? owner : 15);
      check_val("tout", timeout_err, (phase == 3 && u && age == ACK - 1));
      check_val("pre", preempt, want_preempt(e));
      seen_tout = timeout_err;
      seen_pre  = preempt;
      @(posedge clk);
      model_step(e, u);
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      m_reqs = '0; m_blocked = '0; bus_util = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_state", state, 0);
      check_val("rst_grants", m_grants, 0);
      check_val("rst_mid", mid_current, 4'hF);
      check_val("rst_pre", preempt, 0);
      check_val("rst_tout", timeout_err, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
   endtask

   task automatic wait_grant(input logic [11:0] r, input logic [11:0] b, output int mid);
      mid = -1;
      for (int i = 0; i < 20 && mid < 0; i++) begin
         cycle(r, b, 1'b1);
         #1;
         if (mid_current != 4'hF) mid = mid_current;
      end
      if (mid < 0) check_val("grant_bound", (mid_current != 4'hF), 1);
      else $display("grant mid=%0d t=%0t", mid, $time);
   endtask

   int mid;
   int order [5] = '{0, 1, 2, 3, 0};

   initial begin
      rstn = 1'b0;
      m_reqs = '0; m_blocked = '0; bus_util = 1'b1;

      // 1: single request, grant on 3rd clock, release clears grant
      apply_reset();
      repeat (3) cycle(12'h001, 12'h000, 1'b1);
      #1;
      check_val("t1_grant", m_grants, 12'h001);
      check_val("t1_mid", mid_current, 0);
      cycle(12'h001, 12'h000, 1'b0);
      cycle(12'h001, 12'h000, 1'b1);
      #1;
      check_val("t1_rel_grant", m_grants, 0);
      check_val("t1_rel_mid", mid_current, 4'hF);

      // 2: round robin in P1
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         wait_grant(12'h00F, 12'h000, mid);
         check_val("t2_order", mid, order[i]);
         cycle(12'h00F, 12'h000, 1'b0);
         cycle(12'h00F, 12'h000, 1'b0);
         cycle(12'h00F, 12'h000, 1'b1);
      end

      // 3: class priority, then blocking masks the P2 request
      apply_reset();
      wait_grant(12'h110, 12'h000, mid);
      check_val("t3_p2", mid, 4);
      cycle(12'h110, 12'h000, 1'b0);
      cycle(12'h110, 12'h000, 1'b1);
      wait_grant(12'h110, 12'h010, mid);
      check_val("t3_blk", mid, 8);
      cycle(12'h110, 12'h010, 1'b0);
      cycle(12'h000, 12'h000, 1'b1);

      // 4: pickup timeout on GRANT cycle 8, turn passes to mid 6
      apply_reset();
      wait_grant(12'h020, 12'h000, mid);
      check_val("t4_mid", mid, 5);
      for (int k = 1; k <= 8; k++) begin
         cycle(12'h020, 12'h000, 1'b1);
         check_val("t4_tout", seen_tout, (k == 8));
      end
      #1;
      check_val("t4_clr", m_grants, 0);
      check_val("t4_clr_mid", mid_current, 4'hF);
      wait_grant(12'h0F0, 12'h000, mid);
      check_val("t4_next", mid, 6);
      cycle(12'h0F0, 12'h000, 1'b0);
      cycle(12'h000, 12'h000, 1'b1);

      // 5: preempt after 64 HOLD cycles with same-class contender only
      apply_reset();
      wait_grant(12'h003, 12'h000, mid);
      check_val("t5_mid", mid, 0);
      for (int h = 1; h <= 70; h++) begin
         cycle(12'h003, 12'h000, 1'b0);
         check_val("t5_pre", seen_pre, (h >= 66));
      end
      cycle(12'h003, 12'h000, 1'b1);
      #1;
      check_val("t5_pre_rel", preempt, 0);
      wait_grant(12'h201, 12'h000, mid);
      check_val("t5b_mid", mid, 0);
      for (int h = 1; h <= 70; h++) begin
         cycle(12'h201, 12'h000, 1'b0);
         check_val("t5b_pre", seen_pre, 0);
      end

      // 6: asynchronous reset during HOLD; pointer restored
      #3;
      rstn = 1'b0;
      #1;
      check_val("t6_grant", m_grants, 0);
      check_val("t6_state", state, 0);
      check_val("t6_mid", mid_current, 4'hF);
      apply_reset();
      wait_grant(12'h003, 12'h000, mid);
      check_val("t6_ptr", mid, 0);
      cycle(12'h003, 12'h000, 1'b0);
      cycle(12'h000, 12'h000, 1'b1);

      // 7: randomized traffic against the model
      apply_reset();
      begin
         logic [11:0] r, b;
         logic        u;
         int          mode;
         logic [3:0]  prev_mid;
         r = '0; b = '0; mode = 0; prev_mid = 4'hF;
         for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 31) == 0) mode = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) r = 12'($urandom) & 12'($urandom | $urandom);
            if ($urandom_range(0, 7) == 0) b = 12'($urandom & $urandom & $urandom);
            case (mode)
               0:       u = 1'($urandom);
               1:       u = ($urandom_range(0, 79) == 0);
               default: u = ($urandom_range(0, 15) != 0);
            endcase
            cycle(r, b, u);
            #1;
            if (mid_current != prev_mid && mid_current != 4'hF)
               $display("grant mid=%0d t=%0t", mid_current, $time);
            prev_mid = mid_current;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_grant_scheduler.md
Name: bus_grant_scheduler

Overview:
- Fair master-grant scheduler for the shared 12-master bus.
- Three fixed-priority classes of 4 masters each: P1 = mid 0-3, P2 = mid 4-7, P3 = mid 8-11.
- Round-robin within a class; split-blocked masters are masked out.
- Enforces a grant-pickup timeout, and requests preemption of long-tenure masters when equal- or higher-class requests are waiting.
- Sits beside the split/slave tracker, which supplies m_blocked.

Parameters:
MAX_TENURE, 64, HOLD cycles before preempt may assert.
ACK_TIMEOUT, 8, GRANT cycles allowed for master pickup.
CNT_W, 8, width of tenure/timeout counter; must hold max(MAX_TENURE, ACK_TIMEOUT).
MID_NONE, 4'hF, "no master" encoding.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
m_reqs  in  12  per-master bus request, level
m_blocked  in  12  1 = master waiting on split slave; ignore its request
bus_util  in  1  1 = bus released/free, 0 = bus held by a master
m_grants  out  12  one-hot grant, registered
mid_current  out  4  granted master id, MID_NONE when none
preempt  out  1  level; asks current master to finish and release
timeout_err  out  1  one-cycle pulse when a grant is not picked up
state  out  3  FSM state, for debug

Behaviour:
- Reset (asynchronous, active-low, rstn = 0):
  - state = IDLE, m_grants = 0, mid_current = MID_NONE, preempt = 0, timeout_err = 0.
  - Counter = 0, all three rr_ptr = 3 (so the first winner in each class is its lowest mid).
  - Reset mid-grant drops the grant in the same cycle, asynchronously.
- Eligible request: elig = m_reqs & ~m_blocked.
- Encodings: IDLE = 0, ARB = 1, WAIT_FREE = 2, GRANT = 3, HOLD = 4.
- IDLE: |elig -> ARB; otherwise stay.
- ARB (exactly 1 cycle):
  - Pick the highest class with any elig bit.
  - Within that class, pick the first elig master scanning from local index rr_ptr[class]+1, wrapping mod 4.
  - Latch mid_sel and cls_sel; go to WAIT_FREE.
  - If elig has cleared by the ARB cycle, go to IDLE.
- WAIT_FREE:
  - elig[mid_sel] = 0 (request withdrawn or newly blocked) -> IDLE, no grant, rr_ptr unchanged.
  - Else bus_util = 1 -> GRANT.
  - Registered outputs: m_grants[mid_sel] = 1 and mid_current = mid_sel from the first GRANT cycle; counter cleared.
- GRANT:
  - Grant held, counter increments each cycle.
  - bus_util = 0 (master picked up the bus) -> HOLD, counter cleared.
  - Counter reaches ACK_TIMEOUT-1 with bus_util still 1:
    - Grant and mid_current dropped next cycle; timeout_err pulses 1 cycle.
    - rr_ptr[cls_sel] = mid_sel[1:0], so the dead master loses its turn; go to IDLE.
- HOLD:
  - Grant held; counter saturates at MAX_TENURE.
  - preempt = 1 while counter >= MAX_TENURE and any elig master other than mid_sel is in class <= cls_sel.
  - preempt deasserts immediately if that condition falls.
  - bus_util = 1 (released) -> IDLE; m_grants = 0, mid_current = MID_NONE, preempt = 0 next cycle.
  - rr_ptr[cls_sel] = mid_sel[1:0].
  - Requests changing in HOLD never revoke the grant; only release or reset does.
- Simultaneous cases:
  - Release and a new request in the same cycle: IDLE then ARB, minimum 3 cycles from release to the next grant.
  - Blocked and request bits rising together: the request is ignored.
- At most one m_grants bit is ever set. m_grants is nonzero only in GRANT/HOLD and always equals onehot(mid_current).
- Counter arithmetic is unsigned and saturating; it never wraps.

Decomposition:
- Shared bus package holds: MID_NONE, class encodings P1/P2/P3, state enum, mid_t (4-bit) typedef, and a function for mid -> one-hot grant decode. The one-hot decode is shared with the split controller.
- One sub-module, rr_pick4: 4-bit request plus 2-bit pointer -> valid flag plus 2-bit winner, purely combinational. Instantiate it three times, once per class.

Test Plan:
- Reset, then m_reqs = 12'h001 with bus_util = 1 -> m_grants = 12'h001 and mid_current = 0 on the 3rd clock after request; bus_util = 0 then 1 -> grants 0, mid_current = F.
- m_reqs = 12'h00F held; each master releases after 2 cycles -> grant order 0, 1, 2, 3, 0.
- m_reqs = 12'h110 -> mid 4 (P2) wins over mid 8 (P3); with m_blocked = 12'h010 -> mid 8 granted.
- Grant to mid 5, bus_util kept at 1 -> timeout_err pulses on GRANT cycle 8; grants cleared; next arbitration in P2 starts at mid 6.
- Mid 0 holds the bus 70 cycles while m_reqs[1] = 1 -> preempt rises after 64 HOLD cycles. Repeat with only m_reqs[9] = 1 -> preempt stays 0.
- rstn pulsed low during HOLD -> m_grants = 0 and state = IDLE before the next clk edge; rr_ptr restored to 3.
